// File: rtl/cpu_access_pkg.sv
// Shared types and CPU control-line encoding for the APB debug-access engine.
package cpu_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HALT_WAIT = 3'd1,
    ST_RUN       = 3'd2,
    ST_DONE      = 3'd3,
    ST_ERR       = 3'd4
  } state_e;

  localparam int unsigned CTRL_W = 16;

  // Control-line bit positions; all lines are active-low except RI
  localparam int unsigned AIN  = 0;
  localparam int unsigned AOUT = 1;
  localparam int unsigned BIN  = 2;
  localparam int unsigned EOUT = 3;
  localparam int unsigned SUB  = 4;
  localparam int unsigned OIN  = 5;
  localparam int unsigned MIN  = 6;
  localparam int unsigned RI   = 7;
  localparam int unsigned RO   = 8;
  localparam int unsigned IIN  = 9;
  localparam int unsigned IOUT = 10;
  localparam int unsigned CE   = 11;
  localparam int unsigned COUT = 12;
  localparam int unsigned JMP  = 13;
  localparam int unsigned HLT  = 14;
  localparam int unsigned NON  = 15;

  localparam logic [CTRL_W-1:0] CTRL_IDLE_DEF = 16'hFF7F;

  function automatic logic [CTRL_W-1:0] ctrl_bit(input int unsigned idx);
    return CTRL_W'(1) << idx;
  endfunction

  // Flipping a line away from its idle level asserts it, whatever its polarity
  function automatic logic [CTRL_W-1:0] ctrl_on(input logic [CTRL_W-1:0] mask);
    return CTRL_IDLE_DEF ^ mask;
  endfunction

endpackage

// File: rtl/cpu_access_seq_if.sv
// APB slave-side signal bundle for the debug-access engine.
interface cpu_access_seq_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/cpu_access_ucode.sv
// Microcode table for the current CPU instruction set; swap this file to retarget
// the debug engine to another CPU.
module cpu_access_ucode
  import cpu_access_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned STEP_W   = 3,
  parameter int unsigned IMM_BASE = 8
) (
  input  logic [ADDR_W-1:0] UC_ADDR,
  input  logic              UC_WRITE,
  input  logic [STEP_W-1:0] UC_STEP,
  output logic              UC_VALID,
  output logic [CTRL_W-1:0] UC_CTRL,
  output logic              UC_LAST,
  output logic              UC_IMM,
  output logic              UC_CAPTURE,
  output logic              UC_SEL_OUT
);

  localparam logic [ADDR_W-1:0] IMM_LO = ADDR_W'(IMM_BASE);
  localparam logic [ADDR_W-1:0] IMM_HI = ADDR_W'(IMM_BASE + 15);

  // Address map: writes load registers/memory, reads capture a bus source
  always_comb begin
    UC_VALID   = 1'b0;
    UC_CTRL    = CTRL_IDLE_DEF;
    UC_LAST    = 1'b0;
    UC_IMM     = 1'b0;
    UC_CAPTURE = 1'b0;
    UC_SEL_OUT = 1'b0;
    if (UC_WRITE && (UC_ADDR >= IMM_LO) && (UC_ADDR <= IMM_HI)) begin
      UC_VALID = 1'b1;
      UC_IMM   = 1'b1;
      UC_CTRL  = ctrl_on(ctrl_bit(AIN));
      UC_LAST  = 1'b1;
    end else if (UC_WRITE) begin
      case (UC_ADDR)
        ADDR_W'(0): begin UC_VALID = 1'b1; UC_CTRL = ctrl_on(ctrl_bit(AIN)); UC_LAST = 1'b1; end
        ADDR_W'(2): begin UC_VALID = 1'b1; UC_CTRL = ctrl_on(ctrl_bit(MIN)); UC_LAST = 1'b1; end
        ADDR_W'(3): begin UC_VALID = 1'b1; UC_CTRL = ctrl_on(ctrl_bit(RI));  UC_LAST = 1'b1; end
        ADDR_W'(4): begin UC_VALID = 1'b1; UC_CTRL = ctrl_on(ctrl_bit(BIN)); UC_LAST = 1'b1; end
        ADDR_W'(6): begin UC_VALID = 1'b1; UC_CTRL = ctrl_on(ctrl_bit(JMP)); UC_LAST = 1'b1; end
        ADDR_W'(7): begin
          UC_VALID = 1'b1;
          if (UC_STEP == '0) begin
            UC_CTRL = ctrl_on(ctrl_bit(IIN));
          end else begin
            UC_CTRL = ctrl_on(ctrl_bit(CE));
            UC_LAST = 1'b1;
          end
        end
        default: ;
      endcase
    end else begin
      case (UC_ADDR)
        ADDR_W'(0): begin
          UC_VALID = 1'b1; UC_CTRL = ctrl_on(ctrl_bit(AOUT)); UC_CAPTURE = 1'b1; UC_LAST = 1'b1;
        end
        ADDR_W'(1): begin
          UC_VALID = 1'b1; UC_CAPTURE = 1'b1; UC_SEL_OUT = 1'b1; UC_LAST = 1'b1;
        end
        ADDR_W'(3): begin
          UC_VALID = 1'b1; UC_CTRL = ctrl_on(ctrl_bit(RO)); UC_CAPTURE = 1'b1; UC_LAST = 1'b1;
        end
        ADDR_W'(5): begin
          UC_VALID = 1'b1; UC_CTRL = ctrl_on(ctrl_bit(EOUT) | ctrl_bit(SUB));
          UC_CAPTURE = 1'b1; UC_LAST = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_access_seq.sv
// APB debug-access engine: one APB transfer runs a halt handshake and a microcode
// sequence on the CPU control lines, returning a captured value on PRDATA.
module cpu_access_seq
  import cpu_access_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned STEP_W   = 3,
  parameter int unsigned NUM_CTRL = 16,
  parameter logic [NUM_CTRL-1:0] CTRL_IDLE = NUM_CTRL'(CTRL_IDLE_DEF),
  parameter int unsigned IMM_BASE = 8,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                PCLK,
  input  logic                PRESET,
  cpu_access_seq_if.slave     apb,
  output logic                HALT_REQ,
  input  logic                HALTED,
  output logic [ADDR_W-1:0]   UC_ADDR,
  output logic                UC_WRITE,
  output logic [STEP_W-1:0]   UC_STEP,
  input  logic                UC_VALID,
  input  logic [NUM_CTRL-1:0] UC_CTRL,
  input  logic                UC_LAST,
  input  logic                UC_IMM,
  input  logic                UC_CAPTURE,
  input  logic                UC_SEL_OUT,
  output logic [DATA_W-1:0]   DEBUG_DATA,
  output logic [NUM_CTRL-1:0] CTRL,
  input  logic [DATA_W-1:0]   BUS,
  input  logic [DATA_W-1:0]   OUTREG
);

  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [STEP_W-1:0] STEP_MAX = '1;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                prev_enable_q;
  logic [DATA_W-1:0]   prdata_q;
  logic                halt_req_q, pready_q, pslverr_q;
  logic                start_c, load_c, capture_c;
  logic [ADDR_W-1:0]   imm_c;

  // A new transfer needs a fresh PENABLE rising edge so a held PENABLE never retriggers
  assign start_c = (state_q == ST_IDLE) && apb.PSEL && apb.PENABLE && !prev_enable_q;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    load_c    = 1'b0;
    capture_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          load_c = 1'b1;
          step_d = '0;
          if (!UC_VALID) begin
            state_d = ST_ERR;
          end else if (HALTED) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HALT_WAIT;
            cnt_d   = '0;
          end
        end
      end
      ST_HALT_WAIT: begin
        // HALTED arriving on the final wait cycle still wins over the timeout
        if (HALTED) begin
          state_d = ST_RUN;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = TO_W'(cnt_q + 1'b1);
        end
      end
      ST_RUN: begin
        capture_c = UC_CAPTURE;
        if (UC_LAST) begin
          state_d = ST_DONE;
        end else if (step_q == STEP_MAX) begin
          state_d = ST_ERR;
        end else begin
          step_d = STEP_W'(step_q + 1'b1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= ST_IDLE;
      step_q        <= '0;
      cnt_q         <= '0;
      prev_enable_q <= 1'b0;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      prdata_q      <= '0;
      halt_req_q    <= 1'b0;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      cnt_q         <= cnt_d;
      prev_enable_q <= apb.PENABLE;
      if (load_c) begin
        addr_q  <= apb.PADDR;
        write_q <= apb.PWRITE;
        wdata_q <= apb.PWDATA;
      end
      if (capture_c) begin
        prdata_q <= UC_SEL_OUT ? OUTREG : BUS;
      end
      halt_req_q <= (state_d inside {ST_HALT_WAIT, ST_RUN, ST_DONE});
      pready_q   <= (state_d inside {ST_DONE, ST_ERR});
      pslverr_q  <= (state_d == ST_ERR);
    end
  end

  // Table lookup follows the live APB request while idle so UC_VALID is ready at start
  assign UC_ADDR  = (state_q == ST_IDLE) ? apb.PADDR  : addr_q;
  assign UC_WRITE = (state_q == ST_IDLE) ? apb.PWRITE : write_q;
  assign UC_STEP  = step_q;

  assign imm_c      = ADDR_W'(addr_q - ADDR_W'(IMM_BASE));
  assign DEBUG_DATA = UC_IMM ? DATA_W'(imm_c) : wdata_q;
  assign CTRL       = (state_q == ST_RUN) ? UC_CTRL : CTRL_IDLE;

  assign HALT_REQ    = halt_req_q;
  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;

endmodule
